btn_pulse_array: RTL and testbench

//  - Parametrised N-channel push-button conditioner; replaces the per-button debouncer instances feeding DataGen.
//  - Per channel: 2-FF synchroniser, counter-based debounce, one-cycle press pulse, stable level, optional auto-repeat.
//  - Sits in the pixel-clock domain (PClk) between board buttons and the direction/command inputs of the video data path.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_pulse_ch.sv | 167 ++++++++++++++++
 rtl/btn_pulse_array.sv | 49 ++++
 tb/tb_btn_pulse_array.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Holds the per-channel FSM state encoding and the counter width calculation.
package btn_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DB_ON  = 2'd1,
      S_HELD   = 2'd2,
      S_DB_OFF = 2'd3
   } btn_state_t;

   // Width needed to hold the largest of the three cycle counts.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/btn_pulse_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press/release pulses.
// Auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined.
module btn_pulse_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_button,
   output logic o_level,
   output logic o_pulse,
   output logic o_release,
   output logic o_pulse_nxt
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam bit               DB_ONE  = (DEBOUNCE_CYCLES == 1);

   logic [1:0]       sync_q;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic             release_q, release_d;
   logic             rep_pulse;
   logic             sync_w;

   assign sync_w = sync_q[1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      pulse_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sync_w) begin
               if (DB_ONE) begin
                  state_d = S_HELD;
                  level_d = 1'b1;
                  pulse_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = S_DB_ON;
                  cnt_d   = ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
         S_DB_ON: begin
            if (!sync_w) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = S_HELD;
               level_d = 1'b1;
               pulse_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         S_HELD: begin
            if (!sync_w) begin
               if (DB_ONE) begin
                  state_d   = S_IDLE;
                  level_d   = 1'b0;
                  release_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  state_d = S_DB_OFF;
                  cnt_d   = ONE;
               end
            end
         end
         S_DB_OFF: begin
            if (sync_w) begin
               state_d = S_HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d   = S_IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] R_DELAY  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] R_PERIOD = CNT_W'(REPEAT_PERIOD);

   logic [CNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
   logic             started_q, started_d;

   // rcnt restarts from zero after each repeat; the target switches from the
   // initial delay to the period once the first repeat has fired.
   always_comb begin
      rcnt_d    = rcnt_q;
      started_d = started_q;
      rep_pulse = 1'b0;
      rcnt_inc  = rcnt_q + ONE;
      if (pulse_d || state_d == S_IDLE) begin
         rcnt_d    = '0;
         started_d = 1'b0;
      end else if (state_q == S_HELD && state_d == S_HELD) begin
         if (rcnt_inc == (started_q ? R_PERIOD : R_DELAY)) begin
            rep_pulse = 1'b1;
            rcnt_d    = '0;
            started_d = 1'b1;
         end else begin
            rcnt_d = rcnt_inc;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rcnt_q    <= '0;
         started_q <= 1'b0;
      end else begin
         rcnt_q    <= rcnt_d;
         started_q <= started_d;
      end
   end
`else
   assign rep_pulse = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q    <= '0;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         pulse_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], i_button};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         pulse_q   <= pulse_d | rep_pulse;
         release_q <= release_d;
      end
   end

   assign o_level     = level_q;
   assign o_pulse     = pulse_q;
   assign o_release   = release_q;
   assign o_pulse_nxt = pulse_d | rep_pulse;

endmodule

// File: rtl/btn_pulse_array.sv
// N-channel push-button conditioner: independent debounced channels plus o_any.
// Optional auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
module btn_pulse_array
   import btn_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_button,
   output logic [NUM_CH-1:0] o_level,
   output logic [NUM_CH-1:0] o_pulse,
   output logic [NUM_CH-1:0] o_release,
   output logic              o_any
);

   logic [NUM_CH-1:0] pulse_nxt;
   logic              any_q;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         btn_pulse_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_button    (i_button[gi]),
            .o_level     (o_level[gi]),
            .o_pulse     (o_pulse[gi]),
            .o_release   (o_release[gi]),
            .o_pulse_nxt (pulse_nxt[gi])
         );
      end
   endgenerate

   // Registered from the channels' next-pulse terms so it lines up with o_pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) any_q <= 1'b0;
      else       any_q <= |pulse_nxt;
   end

   assign o_any = any_q;

endmodule

// File: tb/tb_btn_pulse_array.sv
// Directed bench for btn_pulse_array with NUM_CH=4, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5; honours BTN_AUTOREPEAT_EN.
module tb_btn_pulse_array;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic [3:0] level, pulse, rel;
   logic       any;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] exp_p;

   btn_pulse_array #(
      .NUM_CH          (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_button  (btn),
      .o_level   (level),
      .o_pulse   (pulse),
      .o_release (rel),
      .o_any     (any)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 4'hF;
      // Reset held three cycles with all buttons pressed
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_level", level, 4'h0);
         chk("rst_pulse", pulse, 4'h0);
         chk("rst_release", rel, 4'h0);
         chk("rst_any", {3'b0, any}, 4'h0);
      end
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("post_rst_pulse_early", pulse, 4'h0);
      end
      step();
      chk("post_rst_pulse", pulse, 4'hF);
      chk("post_rst_level", level, 4'hF);
      chk("post_rst_any", {3'b0, any}, 4'h1);
      step();
      chk("post_rst_pulse_once", pulse, 4'h0);
      chk("post_rst_any_once", {3'b0, any}, 4'h0);

      // Release everything
      btn = 4'h0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("rel_all_early", rel, 4'h0);
         chk("rel_all_level_hold", level, 4'hF);
      end
      step();
      chk("rel_all", rel, 4'hF);
      chk("rel_all_level", level, 4'h0);
      step();
      chk("rel_all_once", rel, 4'h0);
      for (int k = 0; k < 3; k++) step();

      // Bounce on ch1: 3 high, 2 low, 3 high, low
      for (int k = 0; k < 14; k++) begin
         if (k < 3 || (k >= 5 && k < 8)) btn = 4'b0010;
         else btn = 4'b0000;
         step();
         chk("bounce_pulse", pulse, 4'h0);
         chk("bounce_level", level, 4'h0);
      end

      // Clean press on ch0
      btn = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("press0_early", pulse, 4'h0);
         chk("press0_level_early", level, 4'h0);
      end
      step();
      chk("press0_pulse", pulse, 4'b0001);
      chk("press0_level", level, 4'b0001);
      chk("press0_any", {3'b0, any}, 4'h1);
      step();
      chk("press0_pulse_once", pulse, 4'h0);
      chk("press0_level_hold", level, 4'b0001);

      // Two-cycle low glitch while held: no release
      btn = 4'b0000;
      step();
      step();
      btn = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("glitch_release", rel, 4'h0);
         chk("glitch_level", level, 4'b0001);
      end

      // Real release of ch0
      btn = 4'b0000;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("rel0_early", rel, 4'h0);
      end
      step();
      chk("rel0_release", rel, 4'b0001);
      chk("rel0_level", level, 4'h0);
      step();
      chk("rel0_once", rel, 4'h0);
      for (int k = 0; k < 3; k++) step();

      // Auto-repeat on ch2
      btn = 4'b0100;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("rep_early", pulse, 4'h0);
      end
      step();
      chk("rep_press", pulse, 4'b0100);
      for (int k = 1; k <= 30; k++) begin
         step();
         exp_p = 4'h0;
`ifdef BTN_AUTOREPEAT_EN
         if (k >= 10 && ((k - 10) % 5) == 0) exp_p = 4'b0100;
`endif
         chk($sformatf("rep_p+%0d", k), pulse, exp_p);
         chk($sformatf("rep_any_p+%0d", k), {3'b0, any}, {3'b0, exp_p[2]});
      end
      btn = 4'b0000;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("rep_rel_early", rel, 4'h0);
         chk("rep_rel_no_pulse", pulse, 4'h0);
      end
      step();
      chk("rep_release", rel, 4'b0100);
      chk("rep_release_pulse", pulse, 4'h0);
      for (int k = 0; k < 3; k++) step();

      // Simultaneous press on ch0 and ch3
      btn = 4'b1001;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("sim_early", pulse, 4'h0);
         chk("sim_any_early", {3'b0, any}, 4'h0);
      end
      step();
      chk("sim_pulse", pulse, 4'b1001);
      chk("sim_any", {3'b0, any}, 4'h1);
      chk("sim_level", level, 4'b1001);
      step();
      chk("sim_pulse_once", pulse, 4'h0);
      chk("sim_any_once", {3'b0, any}, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
